// File: rtl/piano_pkg.sv
// Shared definitions for the keyboard-to-note scheduler: key map, FLUSH code,
// note-code width and scheduler state encodings.
package piano_pkg;

    localparam int NOTE_W = 4;

    localparam logic [7:0] KEY_FLUSH = 8'h20;

    // Index i holds the ASCII key that plays note i+1 (C4 upward).
    localparam logic [7:0] KEY_MAP [8] = '{8'h61, 8'h73, 8'h64, 8'h66,
                                           8'h67, 8'h68, 8'h6A, 8'h6B};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    function automatic logic [NOTE_W-1:0] map_key(input logic [7:0] code);
        logic [NOTE_W-1:0] note;
        note = '0;
        for (int i = 0; i < 8; i++) begin
            if (code == KEY_MAP[i]) begin
                note = NOTE_W'(i + 1);
            end
        end
        return note;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Pending-note queue with show-ahead head output and registered full/empty
// flags; pointers carry one extra bit so full and empty are distinguishable.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk_fpga,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_next = wr_ptr + {{AW{1'b0}}, do_push};
        rd_next = rd_ptr + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            empty  <= (wr_next == rd_next);
            full   <= (wr_next[AW] != rd_next[AW]) &&
                      (wr_next[AW-1:0] == rd_next[AW-1:0]);
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/key_note_scheduler.sv
// Turns UART key bytes into a queue of notes and plays them one at a time,
// each held for NOTE_CYCLES and followed by GAP_CYCLES of silence.
module key_note_scheduler
    import piano_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned NOTE_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 100_000,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic              clk_fpga,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [NOTE_W-1:0] note_code,
    output logic              note_on,
    output logic              queue_full,
    output logic              overflow
);

    if (CLK_FREQ == 0 || NOTE_CYCLES == 0 || GAP_CYCLES == 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("key_note_scheduler: invalid parameter set");
    end

    state_t            state;
    logic [31:0]       timer;
    logic [NOTE_W-1:0] key_note;
    logic [NOTE_W-1:0] fifo_dout;
    logic              is_flush;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    // FLUSH outranks the pop so a flushed queue never hands out a stale head.
    always_comb begin
        key_note = map_key(rx_data);
        is_flush = rx_valid && (rx_data == KEY_FLUSH);
        push     = rx_valid && (key_note != '0);
        pop      = (state == LOAD) && !is_flush;
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NOTE_W)
    ) u_fifo (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (is_flush),
        .din      (key_note),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign queue_full = fifo_full;

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            note_code <= '0;
            note_on   <= 1'b0;
            overflow  <= 1'b0;
        end else if (is_flush) begin
            state     <= IDLE;
            timer     <= '0;
            note_code <= '0;
            note_on   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    note_code <= fifo_dout;
                    note_on   <= 1'b1;
                    timer     <= 32'(NOTE_CYCLES - 1);
                    state     <= PLAY;
                end
                PLAY: begin
                    if (timer == '0) begin
                        note_code <= '0;
                        note_on   <= 1'b0;
                        timer     <= 32'(GAP_CYCLES - 1);
                        state     <= GAP;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        state <= fifo_empty ? IDLE : LOAD;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
